// File: rtl/rr_arb4.sv
// Four-way round-robin arbiter with ack-driven release and hold timeout.
// All outputs are registered; the just-served requester drops to last priority.
module rr_arb4 #(
  parameter int unsigned TMO = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       ack,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       tmo_err
);

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;
  localparam int unsigned CW   = 8;
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t         state, state_n;
  logic [IDW-1:0] ptr, ptr_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [NREQ-1:0] gnt_n;
  logic [IDW-1:0] gnt_id_n;
  logic           tmo_n;

  logic [IDW-1:0] arb_ptr;
  logic [IDW-1:0] search_idx;
  logic [IDW-1:0] win_id;
  logic           win_found;
  logic           release_ev;

  // On release the pointer moves past the current holder before searching.
  assign arb_ptr = (state == GRANT) ? gnt_id + IDW'(1) : ptr;

  // Priority search starting at arb_ptr, wrapping mod 4.
  always_comb begin
    win_found  = 1'b0;
    win_id     = '0;
    search_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      search_idx = arb_ptr + IDW'(i);
      if (!win_found && req[search_idx]) begin
        win_found = 1'b1;
        win_id    = search_idx;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    cnt_n      = cnt;
    gnt_n      = gnt;
    gnt_id_n   = gnt_id;
    tmo_n      = 1'b0;
    release_ev = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (win_found) begin
          state_n  = GRANT;
          gnt_n    = NREQ'(1) << win_id;
          gnt_id_n = win_id;
        end
      end
      GRANT: begin
        release_ev = ack || (cnt == TMO_LAST);
        if (release_ev) begin
          ptr_n = arb_ptr;
          tmo_n = !ack;
          cnt_n = '0;
          if (win_found) begin
            gnt_n    = NREQ'(1) << win_id;
            gnt_id_n = win_id;
          end else begin
            state_n  = IDLE;
            gnt_n    = '0;
            gnt_id_n = '0;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n  = IDLE;
        gnt_n    = '0;
        gnt_id_n = '0;
        cnt_n    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      tmo_err   <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      cnt       <= cnt_n;
      gnt       <= gnt_n;
      gnt_id    <= gnt_id_n;
      gnt_valid <= |gnt_n;
      tmo_err   <= tmo_n;
    end
  end

endmodule

// File: tb/tb_rr_arb4.sv
// Scoreboard bench for rr_arb4: directed scenarios plus random traffic,
// checked against an integer-level model of the arbitration rules.
module tb_rr_arb4;

  localparam int TMO_T = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       ack;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       tmo_err;

  rr_arb4 #(.TMO(TMO_T)) dut (
    .clk(clk), .reset(reset), .req(req), .ack(ack),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       valid;
    logic       tmo;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc_cnt = 0;
  int   checks  = 0;
  int   errors  = 0;

  // Reference model state: holder is -1 when nobody is granted.
  int m_holder;
  int m_ptr;
  int m_hold;
  bit m_tmo;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic int pick(logic [3:0] r, int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic void model_reset();
    m_holder = -1;
    m_ptr    = 0;
    m_hold   = 0;
    m_tmo    = 1'b0;
  endfunction

  function automatic void model_step(logic [3:0] r, logic a);
    m_tmo = 1'b0;
    if (m_holder < 0) begin
      m_holder = pick(r, m_ptr);
      m_hold   = 0;
    end else if (a || m_hold == TMO_T - 1) begin
      m_tmo    = !a;
      m_ptr    = (m_holder + 1) % 4;
      m_holder = pick(r, m_ptr);
      m_hold   = 0;
    end else begin
      m_hold++;
    end
  endfunction

  task automatic check(string name, int act, int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Called at posedge+1: apply inputs, predict the next edge, return at next posedge+1.
  task automatic cycle(logic [3:0] r, logic a);
    exp_t x;
    req = r;
    ack = a;
    model_step(r, a);
    x.cyc   = cyc_cnt + 1;
    x.gnt   = (m_holder < 0) ? 4'b0000 : 4'(1 << m_holder);
    x.id    = (m_holder < 0) ? 2'd0 : 2'(m_holder);
    x.valid = (m_holder >= 0);
    x.tmo   = m_tmo;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_gnt", int'(gnt), 0);
    check("rst_gnt_id", int'(gnt_id), 0);
    check("rst_gnt_valid", int'(gnt_valid), 0);
    check("rst_tmo_err", int'(tmo_err), 0);
    sb.delete();
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Monitor: compare every expectation whose target edge has passed.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
      e = sb.pop_front();
      check("gnt", int'(gnt), int'(e.gnt));
      check("gnt_id", int'(gnt_id), int'(e.id));
      check("gnt_valid", int'(gnt_valid), int'(e.valid));
      check("tmo_err", int'(tmo_err), int'(e.tmo));
    end
  end

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    ack   = 1'b0;
    model_reset();
    #3;
    check("init_gnt", int'(gnt), 0);
    check("init_gnt_valid", int'(gnt_valid), 0);
    check("init_tmo_err", int'(tmo_err), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // All requesting, ack every grant: rotates 0001,0010,0100,1000,0001.
    repeat (6) cycle(4'b1111, 1'b1);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b0);

    // Ack in idle is ignored.
    repeat (3) cycle(4'b0000, 1'b1);

    // Sole requester re-wins after ack; pointer then sits at 3.
    do_reset();
    cycle(4'b0100, 1'b0);
    cycle(4'b0100, 1'b1);
    cycle(4'b0000, 1'b1);
    cycle(4'b1111, 1'b0);
    cycle(4'b1111, 1'b1);

    // Timeout with ack held low, then sole requester re-granted.
    do_reset();
    repeat (10) cycle(4'b0010, 1'b0);

    // Ack on the final hold cycle wins over timeout.
    do_reset();
    cycle(4'b0010, 1'b0);
    repeat (3) cycle(4'b0010, 1'b0);
    cycle(4'b0110, 1'b1);
    cycle(4'b0000, 1'b1);

    // Grant changes ignored while held.
    do_reset();
    cycle(4'b0001, 1'b0);
    cycle(4'b1110, 1'b0);
    cycle(4'b0000, 1'b0);
    cycle(4'b1110, 1'b1);

    // Reset during a 1000 grant; next grant uses pointer 0.
    do_reset();
    cycle(4'b1000, 1'b0);
    cycle(4'b1000, 1'b0);
    req = 4'b1001;
    do_reset();
    cycle(4'b1001, 1'b0);
    cycle(4'b1001, 1'b1);
    cycle(4'b0000, 1'b1);

    // Random traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 79) == 0)
        do_reset();
      else
        cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
    end
    cycle(4'b0000, 1'b1);

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
